// File: rtl/editor_hora_bcd_if.sv
// editor_hora_bcd_if: button pulses, RTC time and edited-time outputs of the time editor
interface editor_hora_bcd_if;
  logic programar, derecha, izquierda, arriba, abajo;
  logic [7:0] hora_in, min_in, seg_in;
  logic [7:0] hora_bcd, min_bcd, seg_bcd;
  logic [1:0] cursor;
  logic editando, escribir;
  modport master (
    output programar, derecha, izquierda, arriba, abajo, hora_in, min_in, seg_in,
    input  hora_bcd, min_bcd, seg_bcd, cursor, editando, escribir
  );
  modport slave (
    input  programar, derecha, izquierda, arriba, abajo, hora_in, min_in, seg_in,
    output hora_bcd, min_bcd, seg_bcd, cursor, editando, escribir
  );
endinterface

// File: rtl/editor_hora_bcd.sv
// editor_hora_bcd: mirrors RTC time, edits hh:mm:ss in BCD with a field cursor, strobes a write on exit
module editor_hora_bcd #(
  parameter logic [7:0] MAX_HORA = 8'h23,
  parameter logic [7:0] MAX_MIN  = 8'h59
) (
  input logic clk,
  input logic reset,
  editor_hora_bcd_if.slave bus
);
  typedef enum logic [1:0] {REPOSO, EDICION, ESCRITURA} state_t;
  state_t state, state_n;
  logic [7:0] hora_q, min_q, seg_q, hora_n, min_n, seg_n;
  logic [1:0] cursor_q, cursor_n;
  logic edit_q, edit_n, wr_q, wr_n;
  logic chg, mov;
  function automatic logic [7:0] paso(input logic [7:0] v, input logic [7:0] max, input logic up);
    if (up) return v == max ? 8'h00 : v[3:0] == 4'h9 ? {v[7:4] + 4'h1, 4'h0} : v + 8'h01;
    return v == 8'h00 ? max : v[3:0] == 4'h0 ? {v[7:4] - 4'h1, 4'h9} : v - 8'h01;
  endfunction
  assign chg = bus.arriba ^ bus.abajo;
  assign mov = bus.derecha ^ bus.izquierda;
  always_comb begin
    state_n  = state;
    hora_n   = hora_q;
    min_n    = min_q;
    seg_n    = seg_q;
    cursor_n = cursor_q;
    edit_n   = 1'b0;
    wr_n     = 1'b0;
    case (state)
      REPOSO: begin
        state_n  = bus.programar ? EDICION : REPOSO;
        edit_n   = bus.programar;
        cursor_n = 2'd0;
        hora_n   = bus.programar ? hora_q : bus.hora_in;
        min_n    = bus.programar ? min_q : bus.min_in;
        seg_n    = bus.programar ? seg_q : bus.seg_in;
      end
      EDICION: begin
        // edits use the cursor before any move in the same cycle
        hora_n   = (chg && cursor_q == 2'd0) ? paso(hora_q, MAX_HORA, bus.arriba) : hora_q;
        min_n    = (chg && cursor_q == 2'd1) ? paso(min_q, MAX_MIN, bus.arriba) : min_q;
        seg_n    = (chg && cursor_q == 2'd2) ? paso(seg_q, MAX_MIN, bus.arriba) : seg_q;
        cursor_n = !mov ? cursor_q
                 : bus.derecha ? (cursor_q == 2'd2 ? 2'd0 : cursor_q + 2'd1)
                 : (cursor_q == 2'd0 ? 2'd2 : cursor_q - 2'd1);
        edit_n   = bus.programar;
        wr_n     = !bus.programar;
        state_n  = bus.programar ? EDICION : ESCRITURA;
      end
      default: begin
        state_n  = REPOSO;
        cursor_n = 2'd0;
        hora_n   = bus.hora_in;
        min_n    = bus.min_in;
        seg_n    = bus.seg_in;
      end
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= REPOSO;
      hora_q   <= 8'h00;
      min_q    <= 8'h00;
      seg_q    <= 8'h00;
      cursor_q <= 2'd0;
      edit_q   <= 1'b0;
      wr_q     <= 1'b0;
    end else begin
      state    <= state_n;
      hora_q   <= hora_n;
      min_q    <= min_n;
      seg_q    <= seg_n;
      cursor_q <= cursor_n;
      edit_q   <= edit_n;
      wr_q     <= wr_n;
    end
  end
  assign bus.hora_bcd = hora_q;
  assign bus.min_bcd  = min_q;
  assign bus.seg_bcd  = seg_q;
  assign bus.cursor   = cursor_q;
  assign bus.editando = edit_q;
  assign bus.escribir = wr_q;
endmodule
